exec_sequencer: RTL and testbench

Multi-cycle control FSM that drives the combinational ALU and shares one memory port between instruction fetch and load/store traffic. It fetches an instruction and lets the external decoder and the ALU evaluate it. It then sequences the memory access, register-file write-back and PC update. It sits between the register file, ALU and the single-port memory, and owns the PC and the instruction register.

---
 rtl/exec_seq_pkg.sv | 51 +++++
 rtl/exec_sequencer_lsu_align.sv | 55 +++++
 rtl/exec_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// Shared types and opcode constants for the execution sequencer and its
// load/store alignment unit.
package exec_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [5:0] OP_LB   = 6'b010011;
  localparam logic [5:0] OP_LH   = 6'b010100;
  localparam logic [5:0] OP_LW   = 6'b010101;
  localparam logic [5:0] OP_LBU  = 6'b010110;
  localparam logic [5:0] OP_LHU  = 6'b010111;
  localparam logic [5:0] OP_SB   = 6'b011000;
  localparam logic [5:0] OP_SH   = 6'b011001;
  localparam logic [5:0] OP_SW   = 6'b011010;
  localparam logic [5:0] OP_JAL  = 6'b100001;
  localparam logic [5:0] OP_JALR = 6'b100010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    size_e size;
    logic  sext;
  } width_t;

  // Unknown opcodes fall back to an unsigned word access.
  function automatic width_t op_width(input logic [5:0] op);
    width_t w;
    w.size = SZ_WORD;
    w.sext = 1'b0;
    case (op)
      OP_LB:         begin w.size = SZ_BYTE; w.sext = 1'b1; end
      OP_LBU, OP_SB: w.size = SZ_BYTE;
      OP_LH:         begin w.size = SZ_HALF; w.sext = 1'b1; end
      OP_LHU, OP_SH: w.size = SZ_HALF;
      default:       ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/exec_sequencer_lsu_align.sv
// Combinational lane logic: store data steering and strobes, load lane
// select with extension, and natural-alignment check for a pending access.
module lsu_align
  import exec_seq_pkg::*;
(
  input  width_t      width_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  input  width_t      chk_width_i,
  input  logic [1:0]  chk_addr_lo_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] ldata_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wdata_o = sdata_i;
    wstrb_o = 4'hF;
    case (width_i.size)
      SZ_BYTE: begin
        wdata_o = {4{sdata_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        wdata_o = {2{sdata_i[15:0]}};
        wstrb_o = 4'b0011 << addr_lo_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (width_i.size)
      SZ_BYTE: ldata_o = {{24{width_i.sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: ldata_o = {{16{width_i.sext & half_sel[15]}}, half_sel};
      default: ldata_o = rdata_i;
    endcase
  end

  assign misaligned_o = ((chk_width_i.size == SZ_HALF) && chk_addr_lo_i[0]) ||
                        ((chk_width_i.size == SZ_WORD) && (chk_addr_lo_i != 2'b00));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM: fetches over a shared single-port memory, sequences
// load/store, register write-back and PC update from the ALU's evaluation.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [5:0]  alu_op,
  input  logic        alu_load,
  input  logic        alu_store,
  input  logic        alu_wr_en,
  input  logic        alu_jump,
  input  logic        alu_branch,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_mem_addr,
  input  logic [31:0] alu_br_off,
  input  logic [31:0] alu_jump_tgt,
  input  logic [31:0] rs2_data,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        halted,
  output logic        trap,
  output logic [31:0] instret,
  output state_e      dbg_state
);

  // Memory handshake: a transfer completes on a rising edge where mem_req and
  // mem_ready are both high; request fields are held constant until then.

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [31:0] addr_q, addr_d;
  width_t      width_q, width_d;
  logic        store_q, store_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] next_pc;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic [31:0] lsu_ldata;
  logic        lsu_mis;
  width_t      exec_width;

  // alu_jump is redundant with the JAL/JALR opcode decode used below.
  logic unused_jump;
  assign unused_jump = alu_jump;

  assign exec_width = op_width(alu_op);

  lsu_align u_lsu_align (
    .width_i       (width_q),
    .addr_lo_i     (addr_q[1:0]),
    .sdata_i       (sdata_q),
    .rdata_i       (rdata_q),
    .chk_width_i   (exec_width),
    .chk_addr_lo_i (alu_mem_addr[1:0]),
    .wdata_o       (lsu_wdata),
    .wstrb_o       (lsu_wstrb),
    .ldata_o       (lsu_ldata),
    .misaligned_o  (lsu_mis)
  );

  always_comb begin
    if (alu_op == OP_JALR)     next_pc = alu_jump_tgt & ~32'h1;
    else if (alu_op == OP_JAL) next_pc = pc_q + alu_jump_tgt;
    else if (alu_branch)       next_pc = pc_q + alu_br_off;
    else                       next_pc = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      addr_q    <= '0;
      width_q   <= '0;
      store_q   <= 1'b0;
      sdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      addr_q    <= addr_d;
      width_q   <= width_d;
      store_q   <= store_d;
      sdata_q   <= sdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    addr_d    = addr_q;
    width_d   = width_q;
    store_d   = store_q;
    sdata_d   = sdata_q;
    rdata_d   = rdata_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    halted    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = (mem_rdata == HALT_WORD) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_load || alu_store) begin
          if (lsu_mis) begin
            trap_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            addr_d  = alu_mem_addr;
            width_d = exec_width;
            store_d = alu_store;
            sdata_d = rs2_data;
            state_d = S_MEM;
          end
        end else if (next_pc[1:0] != 2'b00) begin
          // Unaligned control transfer: stop without retiring the instruction.
          trap_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          rf_we     = alu_wr_en;
          rf_wdata  = alu_result;
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = store_q;
        mem_addr = {addr_q[31:2], 2'b00};
        if (store_q) begin
          mem_wdata = lsu_wdata;
          mem_wstrb = lsu_wstrb;
        end
        if (mem_ready) begin
          if (store_q) begin
            pc_d      = pc_q + 32'd4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            rdata_d = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_wdata  = lsu_ldata;
        pc_d      = pc_q + 32'd4;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instret   = instret_q;
  assign trap      = trap_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized scoreboard bench for exec_sequencer: the bench plays memory and
// ALU/decoder, predicting transfers, write-backs, PC and timing from a model.
module tb_exec_sequencer;
  import exec_seq_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] HALT_W = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] pc, instr, instret;
  logic [5:0]  alu_op;
  logic        alu_load, alu_store, alu_wr_en, alu_jump, alu_branch;
  logic [31:0] alu_result, alu_mem_addr, alu_br_off, alu_jump_tgt, rs2_data;
  logic        rf_we, halted, trap;
  logic [31:0] rf_wdata;
  state_e      dbg_state;

  exec_sequencer #(.RESET_PC(RST_PC), .HALT_WORD(HALT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr),
    .alu_op(alu_op), .alu_load(alu_load), .alu_store(alu_store), .alu_wr_en(alu_wr_en),
    .alu_jump(alu_jump), .alu_branch(alu_branch), .alu_result(alu_result),
    .alu_mem_addr(alu_mem_addr), .alu_br_off(alu_br_off), .alu_jump_tgt(alu_jump_tgt),
    .rs2_data(rs2_data), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .halted(halted), .trap(trap), .instret(instret), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } txn_t;

  int          tests = 0;
  int          fails = 0;
  txn_t        exp_mem_q[$];
  logic [31:0] exp_q[$];
  int          wait_q[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] pc_m, instret_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: per-transfer wait counts come from wait_q; when idle it
  // toggles mem_ready at random, which the DUT must ignore.
  initial begin : responder
    int   left;
    logic busy;
    left = 0; busy = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (rst || !mem_req) begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        if (left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = (!mem_we && mem_m.exists(mem_addr)) ? mem_m[mem_addr] : $urandom;
          busy = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          left--;
        end
      end
    end
  end

  // Monitor: pops expected transfers / write-backs, and checks request stability.
  initial begin : monitor
    logic pend;
    txn_t prev, t;
    pend = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst) pend = 1'b0;
      else begin
        if (pend) begin
          check("req_held", mem_req, 1'b1);
          check("hold_addr", mem_addr, prev.addr);
          check("hold_we", mem_we, prev.we);
          check("hold_strb", mem_wstrb, prev.strb);
          check("hold_data", mem_wdata, prev.data);
        end
        if (mem_req && mem_ready) begin
          if (exp_mem_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL mem_unexpected: got transfer at %h expected none", mem_addr);
          end else begin
            t = exp_mem_q.pop_front();
            check("mem_we", mem_we, t.we);
            check("mem_addr", mem_addr, t.addr);
            if (t.we) begin
              check("mem_wstrb", mem_wstrb, t.strb);
              check("mem_wdata", mem_wdata, t.data);
            end
          end
          pend = 1'b0;
        end else if (mem_req) begin
          pend = 1'b1;
          prev.we = mem_we; prev.addr = mem_addr; prev.strb = mem_wstrb; prev.data = mem_wdata;
        end else pend = 1'b0;
        if (rf_we) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rf_unexpected: got write %h expected none", rf_wdata);
          end else check("rf_wdata", rf_wdata, exp_q.pop_front());
        end
      end
    end
  end

  function automatic int nbytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  task automatic set_alu(input logic [5:0] op, input logic ld, input logic st, input logic wr,
                         input logic br, input logic [31:0] res, input logic [31:0] maddr,
                         input logic [31:0] off, input logic [31:0] tgt, input logic [31:0] rs2);
    alu_op = op; alu_load = ld; alu_store = st; alu_wr_en = wr; alu_branch = br;
    alu_jump = (op == OP_JAL) || (op == OP_JALR);
    alu_result = res; alu_mem_addr = maddr; alu_br_off = off; alu_jump_tgt = tgt; rs2_data = rs2;
  endtask

  task automatic expect_halt(input string name, input logic exp_trap);
    int cyc;
    cyc = 0;
    while (!halted && cyc < 100) begin @(negedge clk); cyc++; end
    check({name, "_halted"}, halted, 1'b1);
    check({name, "_trap"}, trap, exp_trap);
    check({name, "_pc"}, pc, pc_m);
    check({name, "_instret"}, instret, instret_m);
    check({name, "_rf_left"}, 32'(exp_q.size()), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check({name, "_no_req"}, mem_req, 1'b0);
    end
  endtask

  // One instruction: model the outcome, queue expectations, wait for retirement.
  task automatic issue(input logic [5:0] op, input logic ld, input logic st, input logic wr,
                       input logic br, input logic [31:0] res, input logic [31:0] maddr,
                       input logic [31:0] off, input logic [31:0] tgt, input logic [31:0] rs2,
                       input logic [31:0] ldata, input int fwait, input int dwait);
    logic [31:0] word, npc, sh, wd;
    logic [3:0]  strb;
    longint      m, v;
    int          n, lo, cyc, exp_cyc;
    txn_t        t;
    logic        trapped;
    do word = $urandom; while (word == HALT_W);
    mem_m[pc_m] = word;
    t.we = 1'b0; t.addr = pc_m; t.strb = '0; t.data = '0;
    exp_mem_q.push_back(t);
    wait_q.push_back(fwait);
    set_alu(op, ld, st, wr, br, res, maddr, off, tgt, rs2);
    n = nbytes(op);
    lo = int'(maddr % 4);
    trapped = 1'b0;
    exp_cyc = 2 + fwait;
    if (ld || st) begin
      npc = pc_m + 4;
      if ((maddr % n) != 0) trapped = 1'b1;
      else begin
        t.we = st; t.addr = maddr - lo;
        wait_q.push_back(dwait);
        if (ld) begin
          mem_m[t.addr] = ldata;
          sh = ldata >> (8 * lo);
          m = longint'(1) << (8 * n);
          v = longint'(sh) % m;
          if ((op == OP_LB || op == OP_LH) && v >= m / 2) v = v - m;
          exp_q.push_back(32'(v));
          exp_cyc = 4 + fwait + dwait;
        end else begin
          for (int i = 0; i < 4; i++) begin
            strb[i] = (i >= lo) && (i < lo + n);
            wd[8*i +: 8] = rs2[8*(i % n) +: 8];
          end
          t.strb = strb; t.data = wd;
          exp_cyc = 3 + fwait + dwait;
        end
        exp_mem_q.push_back(t);
      end
    end else begin
      if (op == OP_JALR)     npc = tgt & 32'hFFFF_FFFE;
      else if (op == OP_JAL) npc = pc_m + tgt;
      else if (br)           npc = pc_m + off;
      else                   npc = pc_m + 4;
      if ((npc % 4) != 0) trapped = 1'b1;
      else if (wr) exp_q.push_back(res);
    end
    if (trapped) expect_halt("trap", 1'b1);
    else begin
      pc_m = npc;
      instret_m = instret_m + 1;
      cyc = 0;
      while (instret !== instret_m && cyc < 100) begin @(negedge clk); cyc++; end
      check("instret", instret, instret_m);
      check("pc", pc, pc_m);
      check("instr", instr, word);
      check("cycles", 32'(cyc), 32'(exp_cyc));
      check("mem_q_empty", 32'(exp_mem_q.size()), 32'd0);
      check("rf_q_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_mem_q.delete(); exp_q.delete(); wait_q.delete();
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_wstrb", mem_wstrb, 4'h0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_trap", trap, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_pc", pc, RST_PC);
    rst = 1'b0;
    pc_m = RST_PC; instret_m = 32'h0;
    @(negedge clk);
    check("first_fetch_req", mem_req, 1'b1);
    check("first_fetch_addr", mem_addr, RST_PC);
  endtask

  function automatic logic [31:0] rnd_off();
    int k;
    k = int'($urandom_range(0, 128)) - 64;
    return 32'(k * 4);
  endfunction

  initial begin : driver
    int          kind, fw, dw, n, lo;
    logic [5:0]  op;
    logic [31:0] a, w;
    txn_t        t;
    rst = 1'b1;
    set_alu(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    do_reset();

    // Directed cases
    issue(6'b001010, 0, 0, 1, 0, 32'd5, '0, '0, '0, '0, '0, 0, 0);
    issue(OP_LB,  1, 0, 1, 0, '0, 32'h203, '0, '0, '0, 32'h80FF_0000, 0, 0);
    issue(OP_LBU, 1, 0, 1, 0, '0, 32'h203, '0, '0, '0, 32'h80FF_0000, 0, 0);
    issue(OP_SH,  0, 1, 0, 0, '0, 32'h202, '0, '0, 32'h1234_ABCD, '0, 0, 3);
    issue(OP_SW,  0, 1, 0, 0, '0, 32'h204, '0, '0, 32'hDEAD_BEEF, '0, 0, 0);
    issue(OP_LH,  1, 0, 1, 0, '0, 32'h302, '0, '0, '0, 32'h8001_7FFF, 1, 2);
    issue(OP_LHU, 1, 0, 1, 0, '0, 32'h302, '0, '0, '0, 32'h8001_7FFF, 0, 0);
    issue(OP_SB,  0, 1, 0, 0, '0, 32'h305, '0, '0, 32'h0000_00A5, '0, 0, 0);
    issue(OP_JALR, 0, 0, 1, 0, pc_m + 4, '0, '0, 32'h41, '0, '0, 0, 0);
    issue(6'b000100, 0, 0, 0, 1, '0, '0, 32'hFFFF_FFF0, '0, '0, '0, 0, 0);
    issue(OP_JALR, 0, 0, 1, 0, pc_m + 4, '0, '0, 32'h91, '0, '0, 0, 0);
    issue(OP_JAL,  0, 0, 1, 0, pc_m + 4, '0, '0, 32'h20, '0, '0, 0, 0);

    // Randomized program
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      fw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      case (kind)
        0, 1: issue(6'($urandom_range(1, 15)), 0, 0, 1'($urandom_range(0, 1)), 0, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, fw, dw);
        2: issue(6'b000100, 0, 0, 0, 1, $urandom, $urandom, rnd_off(), $urandom, $urandom, $urandom, fw, dw);
        3: issue(6'b000101, 0, 0, 0, 0, $urandom, $urandom, rnd_off(), $urandom, $urandom, $urandom, fw, dw);
        4: issue(OP_JAL, 0, 0, 1, 0, pc_m + 4, $urandom, $urandom, rnd_off(), $urandom, $urandom, fw, dw);
        5: issue(OP_JALR, 0, 0, 1, 0, pc_m + 4, $urandom, $urandom,
                 32'($urandom_range(0, 16383) * 4 + $urandom_range(0, 1)), $urandom, $urandom, fw, dw);
        default: begin
          if (kind < 8) begin
            case ($urandom_range(0, 4))
              0: op = OP_LB; 1: op = OP_LH; 2: op = OP_LW; 3: op = OP_LBU; default: op = OP_LHU;
            endcase
          end else begin
            case ($urandom_range(0, 2))
              0: op = OP_SB; 1: op = OP_SH; default: op = OP_SW;
            endcase
          end
          n = nbytes(op);
          lo = (n == 1) ? int'($urandom_range(0, 3)) : (n == 2) ? 2 * int'($urandom_range(0, 1)) : 0;
          a = 32'h1000_0000 + 32'($urandom_range(0, 255) * 4 + lo);
          issue(op, kind < 8, kind >= 8, 1'b1, 0, $urandom, a, $urandom, $urandom, $urandom, $urandom, fw, dw);
        end
      endcase
    end

    // Misaligned word load traps without touching memory
    issue(OP_LW, 1, 0, 1, 0, '0, 32'h202, '0, '0, '0, '0, 0, 0);

    // Halt instruction
    do_reset();
    mem_m[pc_m] = HALT_W;
    t.we = 1'b0; t.addr = pc_m; t.strb = '0; t.data = '0;
    exp_mem_q.push_back(t);
    wait_q.push_back(0);
    expect_halt("halt_word", 1'b0);
    check("halt_instr", instr, HALT_W);

    // Reset during a stalled load abandons it
    do_reset();
    w = $urandom;
    mem_m[pc_m] = (w == HALT_W) ? 32'h1 : w;
    t.we = 1'b0; t.addr = pc_m; t.strb = '0; t.data = '0;
    exp_mem_q.push_back(t);
    wait_q.push_back(0);
    wait_q.push_back(20);
    set_alu(OP_LW, 1, 0, 1, 0, '0, 32'h1000_0010, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("mid_req_before", mem_req, 1'b1);
    check("mid_addr_before", mem_addr, 32'h1000_0010);
    rst = 1'b1;
    #1;
    check("mid_req_dropped", mem_req, 1'b0);
    check("mid_rf_we", rf_we, 1'b0);
    do_reset();
    issue(6'b001010, 0, 0, 1, 0, 32'h77, '0, '0, '0, '0, '0, 0, 0);

    // Unaligned jump target traps with no write-back
    issue(OP_JALR, 0, 0, 1, 0, pc_m + 4, '0, '0, 32'h0000_0202, '0, '0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
